sram_port_arbiter: RTL and testbench

Single-port SRAM scheduler between the frame encoder (sprite/frame writes) and the frame decoder (display pixel reads). Display reads have absolute priority and a fixed two-cycle latency so VGA pixel timing never slips. Encoder writes are buffered in a small FIFO and drained only inside the write window (render blanking) on cycles with no read. It replaces the ad-hoc `sram_writing` mux at top level and owns every SRAM pin.

---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_wr_fifo.sv | 75 +++++++
 rtl/sram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared SRAM definitions: bus geometry, the per-cycle bus operation type used
// by the port arbiter, the fixed read latency seen by the display path, and
// the arbitration priority function.
// No ports (package).
// ----------------------------------------------------------------------------
package sram_pkg;

  // Bus geometry of the external asynchronous SRAM.
  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;

  // Cycles from a read request to o_rd_valid. The display timing depends on
  // this never changing.
  localparam int SRAM_RD_LATENCY = 2;

  // Type of the bus cycle that is driven onto the SRAM pins.
  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_RD,
    CYC_WR
  } SramCycle;

  // Arbitration for the next bus cycle. Display reads always win, buffered
  // writes drain only inside the write window, otherwise the bus idles.
  function automatic SramCycle next_cycle(input logic rd_req,
                                          input logic wr_avail,
                                          input logic write_window);
    SramCycle cyc;
    cyc = CYC_IDLE;
    if (rd_req) begin
      cyc = CYC_RD;
    end else if (wr_avail && write_window) begin
      cyc = CYC_WR;
    end
    return cyc;
  endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// ----------------------------------------------------------------------------
// sram_wr_fifo
// Synchronous FIFO holding encoder writes until the arbiter finds a free bus
// cycle. Pointers carry one wrap bit above the index so full and empty are
// distinguished without a separate counter. Head entry is visible
// combinationally (first-word fall-through) so the arbiter can register it
// into the SRAM output flops in the same edge that pops it.
//
// Ports:
//   i_clk        in   1      clock, rising edge
//   i_rst        in   1      asynchronous active-high reset (flushes FIFO)
//   i_push       in   1      write request; ignored while full
//   i_push_data  in   WIDTH  entry to store
//   i_pop        in   1      remove head entry; ignored while empty
//   o_head       out  WIDTH  current head entry (valid while !o_empty)
//   o_full       out  1      no free entry (registered state only)
//   o_empty      out  1      no stored entry (registered state only)
// ----------------------------------------------------------------------------
module sram_wr_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // NOTE: every output of an always_comb gets a default at the top of the
  // block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    // Same index, opposite lap: the writer is exactly one lap ahead.
    o_full   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
               (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    push_ok  = i_push && !o_full;
    pop_ok   = i_pop && !o_empty;
    wr_ptr_d = wr_ptr_q + {{IDX_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{IDX_W{1'b0}}, pop_ok};
    o_head   = mem_q[rd_ptr_q[IDX_W-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
// Single-port SRAM scheduler shared by the frame decoder (display reads) and
// the frame encoder (sprite/frame writes). Reads have absolute priority and a
// fixed two-cycle latency. Writes are buffered in a small FIFO and drained one
// per cycle, only while the write window is open and no read is requested.
// All SRAM pins are driven from flops.
//
// Ports:
//   i_clk           in   1       clock, rising edge
//   i_rst           in   1       asynchronous active-high reset
//   i_write_window  in   1       writes may be drained while high
//   i_rd_req        in   1       display read request, sampled every cycle
//   i_rd_addr       in   ADDR_W  read address
//   o_rd_valid      out  1       o_rd_data valid this cycle
//   o_rd_data       out  DATA_W  returned read word
//   i_wr_valid      in   1       encoder write offered
//   i_wr_addr       in   ADDR_W  write address
//   i_wr_data       in   DATA_W  write data
//   o_wr_ready      out  1       FIFO not full (write is taken this edge)
//   o_wr_pending    out  1       FIFO not empty
//   o_sram_addr     out  ADDR_W  SRAM address (registered)
//   o_sram_we_n     out  1       SRAM write enable, active low (registered)
//   o_sram_dq_out   out  DATA_W  write data to the tristate (registered)
//   o_sram_dq_oe    out  1       tristate output enable (registered)
//   i_sram_dq_in    in   DATA_W  SRAM data pins, input side
// ----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W     = sram_pkg::SRAM_ADDR_COUNT,
  parameter int DATA_W     = sram_pkg::SRAM_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_write_window,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_wr_pending,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in
);

  import sram_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // --------------------------------------------------------------------------
  // Write FIFO
  // --------------------------------------------------------------------------
  wr_entry_t push_entry;
  wr_entry_t head_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;

  assign push_entry = '{addr: i_wr_addr, data: i_wr_data};

  sram_wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (i_wr_valid),
    .i_push_data (push_entry),
    .i_pop       (fifo_pop),
    .o_head      (head_entry),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  // Status comes straight from the FIFO pointer flops: no input reaches them
  // combinationally.
  assign o_wr_ready   = !fifo_full;
  assign o_wr_pending = !fifo_empty;

  // --------------------------------------------------------------------------
  // Bus cycle state and SRAM output registers
  // --------------------------------------------------------------------------
  SramCycle          cyc_q, cyc_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic [DATA_W-1:0] sram_dq_out_q, sram_dq_out_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    cyc_d         = next_cycle(i_rd_req, !fifo_empty, i_write_window);
    // The head leaves the FIFO on the same edge that registers it onto the
    // pins, so a WR bus cycle always carries exactly one popped entry.
    fifo_pop      = (cyc_d == CYC_WR);

    // Idle bus: strobes inactive, address and data hold.
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_we_n_d   = 1'b1;
    sram_dq_oe_d  = 1'b0;

    case (cyc_d)
      CYC_RD: begin
        // we_n and oe drop in the same registered cycle the read starts,
        // so no turnaround cycle is needed after a write.
        sram_addr_d = i_rd_addr;
      end
      CYC_WR: begin
        sram_addr_d   = head_entry.addr;
        sram_dq_out_d = head_entry.data;
        sram_we_n_d   = 1'b0;
        sram_dq_oe_d  = 1'b1;
      end
      default: begin
      end
    endcase

    // Read return: the word on the pins during an RD bus cycle is captured
    // at its end, giving the fixed request-to-valid latency of two.
    rd_valid_d = (cyc_q == CYC_RD);
    rd_data_d  = rd_valid_d ? i_sram_dq_in : rd_data_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc_q         <= CYC_IDLE;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      cyc_q         <= cyc_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign o_sram_addr   = sram_addr_q;
  assign o_sram_we_n   = sram_we_n_q;
  assign o_sram_dq_out = sram_dq_out_q;
  assign o_sram_dq_oe  = sram_dq_oe_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. Accepted writes and issued reads push
// their expected results into queues; a negedge monitor pops and compares them
// as WR bus cycles and read returns appear. The SRAM returns a fixed function
// of the address it is driven with.
// ----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  import sram_pkg::*;

  localparam int ADDR_W     = SRAM_ADDR_COUNT;
  localparam int DATA_W     = SRAM_DATA_WIDTH;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              window = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              wr_pending;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_write_window (window),
    .i_rd_req       (rd_req),
    .i_rd_addr      (rd_addr),
    .o_rd_valid     (rd_valid),
    .o_rd_data      (rd_data),
    .i_wr_valid     (wr_valid),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .o_wr_ready     (wr_ready),
    .o_wr_pending   (wr_pending),
    .o_sram_addr    (sram_addr),
    .o_sram_we_n    (sram_we_n),
    .o_sram_dq_out  (sram_dq_out),
    .o_sram_dq_oe   (sram_dq_oe),
    .i_sram_dq_in   (sram_dq_in)
  );

  // SRAM model: contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] sram_pattern(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 16'hC35A;
  endfunction

  assign sram_dq_in = sram_pattern(sram_addr);

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } rd_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  wr_exp_t     wr_pop;
  rd_exp_t     rd_pop;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cycle = 0;
  int unsigned wr_seen = 0;
  int unsigned rd_seen = 0;
  logic        monitor_en = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (monitor_en && !rst) begin
      if (sram_we_n == 1'b0) begin
        wr_seen++;
        check("wr_oe", sram_dq_oe, 1);
        check("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          wr_pop = wr_q.pop_front();
          check("wr_addr", sram_addr, wr_pop.addr);
          check("wr_data", sram_dq_out, wr_pop.data);
        end
      end else begin
        check("nonwr_oe", sram_dq_oe, 0);
      end
      if (rd_valid) begin
        rd_seen++;
        check("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          rd_pop = rd_q.pop_front();
          check("rd_data", rd_data, rd_pop.data);
          check("rd_latency_cycle", cycle, rd_pop.due);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int      tries;
    wr_exp_t e;
    tries    = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && tries < 20) begin
      step();
      tries++;
    end
    check("wr_accept_timeout", wr_ready, 1);
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a);
    rd_exp_t e;
    rd_req  = 1'b1;
    rd_addr = a;
    e.data  = sram_pattern(a);
    e.due   = cycle + SRAM_RD_LATENCY;
    rd_q.push_back(e);
    step();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    step();
    check({tag, "_wr_left"}, wr_q.size(), 0);
    check({tag, "_rd_left"}, rd_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int unsigned seen0;
    int unsigned accepted;
    wr_exp_t     e;

    // Reset state
    step();
    step();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe", sram_dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_pending", wr_pending, 0);
    rst = 1'b0;
    monitor_en = 1'b1;
    step();

    // Single write: WR two cycles after acceptance, then idle with held bus
    window = 1'b1;
    offer_write(20'h00010, 16'hBEEF);
    check("sw_pending", wr_pending, 1);
    check("sw_not_yet", sram_we_n, 1);
    step();
    check("sw_we_n", sram_we_n, 0);
    check("sw_addr", sram_addr, 20'h00010);
    check("sw_dq", sram_dq_out, 16'hBEEF);
    step();
    check("sw_idle_we_n", sram_we_n, 1);
    check("sw_idle_oe", sram_dq_oe, 0);
    check("sw_idle_addr_hold", sram_addr, 20'h00010);
    check("sw_idle_dq_hold", sram_dq_out, 16'hBEEF);
    check("sw_pending_clear", wr_pending, 0);

    // Reads preempt queued writes
    window = 1'b0;
    for (int i = 0; i < 3; i++) offer_write(20'h00200 + 20'(i), 16'h1000 + 16'(i));
    seen0  = rd_seen;
    window = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_read(20'h00100 + 20'(i));
      check("rp_rd_addr", sram_addr, 20'h00100 + 20'(i));
      check("rp_no_wr", sram_we_n, 1);
    end
    rd_req = 1'b0;
    step();
    check("rp_first_wr", sram_we_n, 0);
    check("rp_first_wr_addr", sram_addr, 20'h00200);
    wait_drain("rp");
    check("rp_rd_count", rd_seen - seen0, 5);

    // FIFO full with the window closed
    window   = 1'b0;
    accepted = 0;
    seen0    = wr_seen;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 20'h00300 + 20'(accepted);
      wr_data  = 16'h3000 + 16'(accepted);
      check("full_ready", wr_ready, (i < 4) ? 1 : 0);
      if (wr_ready) begin
        e.addr = wr_addr;
        e.data = wr_data;
        wr_q.push_back(e);
        accepted++;
      end
      step();
    end
    wr_valid = 1'b0;
    check("full_accepted", accepted, 4);
    check("full_no_wr", wr_seen - seen0, 0);
    window = 1'b1;
    check("full_ready_before_pop", wr_ready, 0);
    step();
    check("full_ready_after_pop", wr_ready, 1);
    check("full_first_wr", sram_we_n, 0);
    wait_drain("full");
    check("full_wr_count", wr_seen - seen0, 4);

    // Push and pop on the same edge at level 2
    window = 1'b0;
    offer_write(20'h00400, 16'h4000);
    offer_write(20'h00401, 16'h4001);
    window   = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 20'h00402;
    wr_data  = 16'h4002;
    check("pp_ready", wr_ready, 1);
    e.addr = wr_addr;
    e.data = wr_data;
    wr_q.push_back(e);
    step();
    wr_valid = 1'b0;
    window   = 1'b0;
    check("pp_popped_wr", sram_we_n, 0);
    check("pp_pending", wr_pending, 1);
    offer_write(20'h00403, 16'h4003);
    offer_write(20'h00404, 16'h4004);
    check("pp_level_full", wr_ready, 0);
    window = 1'b1;
    wait_drain("pp");

    // Reset between a read request and its return, with writes queued
    window = 1'b0;
    offer_write(20'h00500, 16'h5000);
    offer_write(20'h00501, 16'h5001);
    issue_read(20'h00155);
    rd_req = 1'b0;
    rst    = 1'b1;
    wr_q.delete();
    rd_q.delete();
    #1;
    check("mr_we_n", sram_we_n, 1);
    check("mr_oe", sram_dq_oe, 0);
    check("mr_addr", sram_addr, 0);
    check("mr_pending", wr_pending, 0);
    check("mr_ready", wr_ready, 1);
    check("mr_rd_valid", rd_valid, 0);
    step();
    check("mr_rd_valid_held", rd_valid, 0);
    step();
    rst    = 1'b0;
    window = 1'b1;
    seen0  = wr_seen;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_post_rd_valid", rd_valid, 0);
      check("mr_post_we_n", sram_we_n, 1);
    end
    check("mr_no_wr", wr_seen - seen0, 0);
    check("mr_pending_after", wr_pending, 0);

    // Window closes while draining
    window = 1'b0;
    offer_write(20'h00700, 16'h7000);
    offer_write(20'h00701, 16'h7001);
    window = 1'b1;
    step();
    window = 1'b0;
    check("wc_registered_wr", sram_we_n, 0);
    check("wc_registered_addr", sram_addr, 20'h00700);
    check("wc_pending", wr_pending, 1);
    step();
    check("wc_wait1", sram_we_n, 1);
    step();
    check("wc_wait2", sram_we_n, 1);
    check("wc_still_pending", wr_pending, 1);
    window = 1'b1;
    issue_read(20'h00600);
    issue_read(20'h00601);
    rd_req = 1'b0;
    check("wc_rd_on_bus", sram_we_n, 1);
    step();
    check("wc_resume_wr", sram_we_n, 0);
    check("wc_resume_addr", sram_addr, 20'h00701);
    check("wc_resume_dq", sram_dq_out, 16'h7001);
    wait_drain("wc");
    check("wc_pending_clear", wr_pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
